// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Arbitrates a read-burst port, a write-burst port and periodic refresh onto
//   a single SDRAM controller command channel.
//
// Ports
//   i_clk, i_rstn         clock, asynchronous active-low reset
//   i_wr_req, i_wr_addr   write-burst request and start address
//   i_rd_req, i_rd_addr   read-burst request and start address
//   i_rd_urgent           read FIFO below low-water mark (read jumps the queue)
//   o_wr_grant/o_rd_grant single-cycle pulse, cycle after command acceptance
//   o_wr_done/o_rd_done   single-cycle pulse, cycle after i_cmd_done
//   o_cmd_valid/type/addr command to controller (type 00 rd, 01 wr, 10 refresh)
//   i_cmd_ready           controller accepts command when high with o_cmd_valid
//   i_cmd_done            controller finished the outstanding burst/refresh
//   o_busy                a command is outstanding (ISSUE or WAIT_DONE)
//   o_refresh_overrun     sticky: refresh interval expired with one still pending
//   o_timeout_err         sticky: watchdog expired waiting for i_cmd_done
module sdram_arbiter #(
  parameter int REFRESH_CYCLES = 499,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wr_req,
  input  logic [22:0] i_wr_addr,
  input  logic        i_rd_req,
  input  logic [22:0] i_rd_addr,
  input  logic        i_rd_urgent,
  output logic        o_wr_grant,
  output logic        o_rd_grant,
  output logic        o_wr_done,
  output logic        o_rd_done,
  output logic        o_cmd_valid,
  output logic [1:0]  o_cmd_type,
  output logic [22:0] o_cmd_addr,
  input  logic        i_cmd_ready,
  input  logic        i_cmd_done,
  output logic        o_busy,
  output logic        o_refresh_overrun,
  output logic        o_timeout_err
);

  localparam logic [1:0] CMD_RD  = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_REF = 2'b10;

  localparam int RW = $clog2(REFRESH_CYCLES) + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic          ref_tick;
  logic          refresh_pending;
  logic          favour_wr;
  logic [WW-1:0] wd_cnt;

  logic          arb_valid;
  logic [1:0]    arb_type;
  logic [22:0]   arb_addr;

  // Free-running refresh interval timer; runs regardless of FSM state.
  assign ref_tick = (ref_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ref_cnt <= REF_RELOAD;
    end else if (ref_tick) begin
      ref_cnt <= REF_RELOAD;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
    end
  end

  // Priority: pending refresh, urgent read, then round-robin. A read wins the
  // non-urgent contest unless a write is also asking and is the favoured port.
  always_comb begin
    arb_valid = 1'b0;
    arb_type  = CMD_RD;
    arb_addr  = '0;
    if (refresh_pending) begin
      arb_valid = 1'b1;
      arb_type  = CMD_REF;
    end else if (i_rd_req && (i_rd_urgent || !i_wr_req || !favour_wr)) begin
      arb_valid = 1'b1;
      arb_type  = CMD_RD;
      arb_addr  = i_rd_addr;
    end else if (i_wr_req) begin
      arb_valid = 1'b1;
      arb_type  = CMD_WR;
      arb_addr  = i_wr_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state             <= IDLE;
      refresh_pending   <= 1'b0;
      favour_wr         <= 1'b0;
      wd_cnt            <= '0;
      o_wr_grant        <= 1'b0;
      o_rd_grant        <= 1'b0;
      o_wr_done         <= 1'b0;
      o_rd_done         <= 1'b0;
      o_cmd_valid       <= 1'b0;
      o_cmd_type        <= CMD_RD;
      o_cmd_addr        <= '0;
      o_busy            <= 1'b0;
      o_refresh_overrun <= 1'b0;
      o_timeout_err     <= 1'b0;
    end else begin
      o_wr_grant <= 1'b0;
      o_rd_grant <= 1'b0;
      o_wr_done  <= 1'b0;
      o_rd_done  <= 1'b0;

      case (state)
        IDLE: begin
          if (arb_valid) begin
            state       <= ISSUE;
            o_cmd_valid <= 1'b1;
            o_cmd_type  <= arb_type;
            o_cmd_addr  <= arb_addr;
            o_busy      <= 1'b1;
          end
        end

        ISSUE: begin
          if (i_cmd_ready) begin
            state       <= WAIT_DONE;
            o_cmd_valid <= 1'b0;
            wd_cnt      <= '0;
            // Refresh leaves the round-robin pointer untouched.
            if (o_cmd_type == CMD_RD) begin
              o_rd_grant <= 1'b1;
              favour_wr  <= 1'b1;
            end else if (o_cmd_type == CMD_WR) begin
              o_wr_grant <= 1'b1;
              favour_wr  <= 1'b0;
            end
          end
        end

        WAIT_DONE: begin
          if (i_cmd_done) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_rd_done <= (o_cmd_type == CMD_RD);
            o_wr_done <= (o_cmd_type == CMD_WR);
          end else if (wd_cnt == WD_LAST) begin
            state         <= IDLE;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // A fresh interval expiry outranks clearing by an accepted refresh, so
      // a request arriving in the acceptance cycle is never lost.
      if (ref_tick) begin
        refresh_pending <= 1'b1;
        if (refresh_pending) o_refresh_overrun <= 1'b1;
      end else if (state == ISSUE && i_cmd_ready && o_cmd_type == CMD_REF) begin
        refresh_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: two instances (refresh every 16 cycles; watchdog 64
// and 8 cycles) share one stimulus stream. A behavioural model per instance is
// compared every cycle, and directed scenarios pin hand-computed values.
module tb_sdram_arbiter;

  localparam int RC = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0, rd_urgent = 1'b0;
  logic        cmd_ready = 1'b0, cmd_done = 1'b0;
  logic [22:0] wr_addr = '0, rd_addr = '0;

  logic        a_wr_grant, a_rd_grant, a_wr_done, a_rd_done, a_cmd_valid;
  logic [1:0]  a_cmd_type;
  logic [22:0] a_cmd_addr;
  logic        a_busy, a_refresh_overrun, a_timeout_err;
  logic        b_wr_grant, b_rd_grant, b_wr_done, b_rd_done, b_cmd_valid;
  logic [1:0]  b_cmd_type;
  logic [22:0] b_cmd_addr;
  logic        b_busy, b_refresh_overrun, b_timeout_err;
  logic [32:0] a_vec, b_vec;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.REFRESH_CYCLES(RC), .TIMEOUT_CYCLES(64)) dut_a (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_urgent(rd_urgent),
    .o_wr_grant(a_wr_grant), .o_rd_grant(a_rd_grant),
    .o_wr_done(a_wr_done), .o_rd_done(a_rd_done),
    .o_cmd_valid(a_cmd_valid), .o_cmd_type(a_cmd_type), .o_cmd_addr(a_cmd_addr),
    .i_cmd_ready(cmd_ready), .i_cmd_done(cmd_done),
    .o_busy(a_busy), .o_refresh_overrun(a_refresh_overrun), .o_timeout_err(a_timeout_err)
  );

  sdram_arbiter #(.REFRESH_CYCLES(RC), .TIMEOUT_CYCLES(8)) dut_b (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_urgent(rd_urgent),
    .o_wr_grant(b_wr_grant), .o_rd_grant(b_rd_grant),
    .o_wr_done(b_wr_done), .o_rd_done(b_rd_done),
    .o_cmd_valid(b_cmd_valid), .o_cmd_type(b_cmd_type), .o_cmd_addr(b_cmd_addr),
    .i_cmd_ready(cmd_ready), .i_cmd_done(cmd_done),
    .o_busy(b_busy), .o_refresh_overrun(b_refresh_overrun), .o_timeout_err(b_timeout_err)
  );

  assign a_vec = {a_cmd_valid, a_cmd_type, a_cmd_addr, a_busy, a_wr_grant, a_rd_grant,
                  a_wr_done, a_rd_done, a_refresh_overrun, a_timeout_err};
  assign b_vec = {b_cmd_valid, b_cmd_type, b_cmd_addr, b_busy, b_wr_grant, b_rd_grant,
                  b_wr_done, b_rd_done, b_refresh_overrun, b_timeout_err};

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for work, 1 offering a command, 2 command outstanding
  typedef struct {
    int          to;
    int          phase;
    int          rcnt;
    int          wd;
    bit          pend, ovr, terr, favwr;
    bit          valid, busy, wg, rg, wdn, rdn;
    logic [1:0]  typ;
    logic [22:0] addr;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_rst(int to);
    mdl_t s;
    s.to = to; s.phase = 0; s.rcnt = RC - 1; s.wd = 0;
    s.pend = 1'b0; s.ovr = 1'b0; s.terr = 1'b0; s.favwr = 1'b0;
    s.valid = 1'b0; s.busy = 1'b0; s.wg = 1'b0; s.rg = 1'b0; s.wdn = 1'b0; s.rdn = 1'b0;
    s.typ = 2'b00; s.addr = '0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s);
    mdl_t n;
    bit   tick;
    int   w;
    n = s;
    tick = (s.rcnt == 0);
    n.wg = 1'b0; n.rg = 1'b0; n.wdn = 1'b0; n.rdn = 1'b0;
    n.rcnt = tick ? RC - 1 : s.rcnt - 1;
    if (s.phase == 0) begin
      w = -1;                                   // 0 read, 1 write, 2 refresh
      if (s.pend) w = 2;
      else if (rd_req && rd_urgent) w = 0;
      else if (rd_req && wr_req) w = s.favwr ? 1 : 0;
      else if (rd_req) w = 0;
      else if (wr_req) w = 1;
      if (w >= 0) begin
        n.phase = 1; n.valid = 1'b1; n.busy = 1'b1; n.typ = 2'(w);
        n.addr = (w == 0) ? rd_addr : (w == 1) ? wr_addr : 23'd0;
      end
    end else if (s.phase == 1) begin
      if (cmd_ready) begin
        n.phase = 2; n.valid = 1'b0; n.wd = 0;
        if (s.typ == 2'd0) begin n.rg = 1'b1; n.favwr = 1'b1; end
        else if (s.typ == 2'd1) begin n.wg = 1'b1; n.favwr = 1'b0; end
        else n.pend = 1'b0;
      end
    end else begin
      if (cmd_done) begin
        n.phase = 0; n.busy = 1'b0;
        n.rdn = (s.typ == 2'd0); n.wdn = (s.typ == 2'd1);
      end else if (s.wd == s.to - 1) begin
        n.phase = 0; n.busy = 1'b0; n.terr = 1'b1;
      end else begin
        n.wd = s.wd + 1;
      end
    end
    if (tick) begin
      if (s.pend) n.ovr = 1'b1;
      n.pend = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [32:0] mdl_pack(mdl_t s);
    return {s.valid, s.typ, s.addr, s.busy, s.wg, s.rg, s.wdn, s.rdn, s.ovr, s.terr};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ma = mdl_rst(64);
      mb = mdl_rst(8);
    end else begin
      ma = mdl_step(ma);
      mb = mdl_step(mb);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_a", 64'(a_vec), 64'(mdl_pack(ma)));
    chk("model_b", 64'(b_vec), 64'(mdl_pack(mb)));
  end

  // ---------------- directed helpers (drive/sample on negedge) ----------------
  task automatic run_cmd(input int lat_wr, output logic [1:0] typ, output logic [22:0] addr);
    int n;
    bit got;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (a_cmd_valid && cmd_ready) got = 1'b1;
      else n++;
    end
    chk("accept_seen", 64'(got), 64'(1));
    if (!got) begin
      typ = 2'b11; addr = '0;
      return;
    end
    typ = a_cmd_type; addr = a_cmd_addr;
    @(negedge clk);
    chk("rd_grant", 64'(a_rd_grant), 64'(typ == 2'b00));
    chk("wr_grant", 64'(a_wr_grant), 64'(typ == 2'b01));
    repeat (((typ == 2'b01) ? lat_wr : 2) - 1) @(negedge clk);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("rd_done", 64'(a_rd_done), 64'(typ == 2'b00));
    chk("wr_done", 64'(a_wr_done), 64'(typ == 2'b01));
  endtask

  // Serve commands until a read or write (not a refresh) has completed.
  task automatic run_rw(input int lat_wr, output logic [1:0] typ, output logic [22:0] addr);
    typ = 2'b10; addr = '0;
    for (int i = 0; i < 4 && typ == 2'b10; i++) run_cmd(lat_wr, typ, addr);
    chk("rw_served", 64'(typ != 2'b10 && typ != 2'b11), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [1:0]  t;
    logic [22:0] ad;
    logic [1:0]  exp29 [4];
    int          k, nseq;
    bit          saw_done;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_a", 64'(a_vec), 64'(0));
    chk("rst_b", 64'(b_vec), 64'(0));
    rstn = 1'b1;

    // done while idle is ignored
    @(negedge clk); cmd_done = 1'b1;
    @(negedge clk); cmd_done = 1'b0;
    chk("idle_done_ignored", 64'({a_rd_done, a_wr_done, a_busy}), 64'(0));

    // single write, cycle by cycle; request dropped right after arbitration
    cmd_ready = 1'b1;
    @(negedge clk); wr_addr = 23'h000200; wr_req = 1'b1;
    @(negedge clk);
    chk("w_valid", 64'(a_cmd_valid), 64'(1));
    chk("w_type", 64'(a_cmd_type), 64'(2'b01));
    chk("w_addr", 64'(a_cmd_addr), 64'(23'h000200));
    chk("w_busy", 64'(a_busy), 64'(1));
    wr_req = 1'b0;
    @(negedge clk);
    chk("w_grant", 64'(a_wr_grant), 64'(1));
    chk("w_valid_off", 64'(a_cmd_valid), 64'(0));
    @(negedge clk);
    chk("w_grant_1cyc", 64'(a_wr_grant), 64'(0));
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("w_done", 64'(a_wr_done), 64'(1));
    chk("w_idle", 64'(a_busy), 64'(0));
    @(negedge clk);
    chk("w_done_1cyc", 64'(a_wr_done), 64'(0));

    // watchdog on instance b: read accepted, no done ever
    rd_addr = 23'h0000AB; rd_req = 1'b1;
    @(negedge clk);
    chk("t_valid", 64'(b_cmd_valid), 64'(1));
    chk("t_type", 64'(b_cmd_type), 64'(2'b00));
    rd_req = 1'b0;
    @(negedge clk);
    chk("t_grant", 64'(b_rd_grant), 64'(1));
    k = 0; saw_done = 1'b0;
    while (!b_timeout_err && k < 20) begin
      @(negedge clk);
      k++;
      if (b_rd_done || b_wr_done) saw_done = 1'b1;
    end
    chk("t_cycles", 64'(k), 64'(8));
    chk("t_no_done", 64'(saw_done), 64'(0));
    chk("t_idle", 64'(b_busy), 64'(0));
    chk("t_a_waiting", 64'(a_busy), 64'(1));

    // asynchronous reset while instance a waits for done
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("areset_a", 64'(a_vec), 64'(0));
    chk("areset_b", 64'(b_vec), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // served normally after reset
    wr_addr = 23'h000123; wr_req = 1'b1;
    run_rw(2, t, ad);
    wr_req = 1'b0;
    chk("post_rst_type", 64'(t), 64'(2'b01));
    chk("post_rst_addr", 64'(ad), 64'(23'h000123));

    // both held: R, W, R, W
    exp29 = '{2'b00, 2'b01, 2'b00, 2'b01};
    rd_addr = 23'h000111; wr_addr = 23'h000222;
    rd_req = 1'b1; wr_req = 1'b1;
    nseq = 0;
    for (int i = 0; i < 10 && nseq < 4; i++) begin
      run_cmd(2, t, ad);
      if (t == 2'b00 || t == 2'b01) begin
        chk("rr_order", 64'(t), 64'(exp29[nseq]));
        chk("rr_addr", 64'(ad), 64'((t == 2'b00) ? 23'h000111 : 23'h000222));
        nseq++;
      end
    end
    chk("rr_count", 64'(nseq), 64'(4));
    wr_req = 1'b0;

    // urgent read wins even though read was granted last
    run_rw(2, t, ad);
    chk("u_pre_read", 64'(t), 64'(2'b00));
    wr_req = 1'b1; rd_urgent = 1'b1;
    run_rw(2, t, ad);
    chk("u_read_wins", 64'(t), 64'(2'b00));
    rd_urgent = 1'b0;
    run_rw(2, t, ad);
    chk("u_then_write", 64'(t), 64'(2'b01));
    wr_req = 1'b0;
    run_rw(2, t, ad);
    chk("o_pre_read", 64'(t), 64'(2'b00));

    // long write burst overruns refresh; refresh goes first afterwards
    chk("o_before", 64'(a_refresh_overrun), 64'(0));
    wr_addr = 23'h000300; wr_req = 1'b1;
    run_rw(40, t, ad);
    chk("o_write", 64'(t), 64'(2'b01));
    chk("o_overrun", 64'(a_refresh_overrun), 64'(1));
    run_cmd(2, t, ad);
    chk("o_ref_type", 64'(t), 64'(2'b10));
    chk("o_ref_addr", 64'(ad), 64'(0));
    run_rw(2, t, ad);
    chk("o_then_read", 64'(t), 64'(2'b00));
    rd_req = 1'b0; wr_req = 1'b0;
    chk("o_sticky", 64'(a_refresh_overrun), 64'(1));

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 499, giving the clock cycles between refresh requests (7.8 us at 64 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum number of cycles from command acceptance to i_cmd_done.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock, shared with the SDRAM controller.
REQ-004 SHALL have port i_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports i_wr_req (in, 1: write-burst request) and i_wr_addr (in, 23: write start address).
REQ-006 SHALL have ports i_rd_req (in, 1: read-burst request), i_rd_addr (in, 23: read start address) and i_rd_urgent (in, 1: read FIFO below low-water mark).
REQ-007 SHALL have ports o_wr_grant, o_rd_grant, o_wr_done and o_rd_done (out, 1 each): single-cycle pulses.
REQ-008 SHALL have ports o_cmd_valid (out, 1), o_cmd_type (out, 2; 00 read, 01 write, 10 refresh), o_cmd_addr (out, 23) and i_cmd_ready (in, 1): controller command handshake.
REQ-009 SHALL have ports i_cmd_done (in, 1: burst/refresh complete pulse), o_busy (out, 1), o_refresh_overrun (out, 1, sticky) and o_timeout_err (out, 1, sticky).

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE and WAIT_DONE.
REQ-011 SHALL use a down-counter in refresh timing: load REFRESH_CYCLES-1, decrement every cycle, and at 0 set refresh_pending and reload.
REQ-012 SHALL set o_refresh_overrun if the refresh counter hits 0 while refresh_pending is already 1; refresh_pending stays 1 (saturates, no queueing).
REQ-013 SHALL, in IDLE, arbitrate in the same cycle, in priority order:
- refresh_pending
- i_rd_req with i_rd_urgent
- round-robin between i_rd_req and i_wr_req, favouring the port not granted last; after reset, read is favoured.
REQ-014 SHALL, when arbitration selects a winner, register o_cmd_type and o_cmd_addr (refresh: addr = 0) and go to ISSUE the next cycle; IDLE with no requests stays IDLE.
REQ-015 SHALL, in ISSUE, hold o_cmd_valid = 1 with stable type and address until i_cmd_ready = 1.
REQ-016 SHALL treat the cycle with o_cmd_valid and i_cmd_ready both high as acceptance; the next cycle is WAIT_DONE.
REQ-017 SHALL pulse o_rd_grant or o_wr_grant (per the accepted type) for one cycle, in the cycle after acceptance.
REQ-018 SHALL clear refresh_pending on acceptance of a refresh command; no grant pulse is issued for refresh.
REQ-019 SHALL latch request addresses at arbitration; a requester deasserting its request after arbitration does not cancel the command.
REQ-020 SHALL, in WAIT_DONE on i_cmd_done = 1, go to IDLE and pulse the matching o_rd_done or o_wr_done in the next cycle; refresh completion pulses neither.
REQ-021 SHALL ignore i_cmd_done outside WAIT_DONE.
REQ-022 SHALL run a watchdog in WAIT_DONE, counting from 0. If it reaches TIMEOUT_CYCLES-1 without i_cmd_done:
- set o_timeout_err
- return to IDLE
- issue no done pulse.
REQ-023 SHALL, when the refresh counter expires in the same cycle as i_cmd_done, set refresh_pending so refresh wins the next IDLE arbitration.
REQ-024 SHALL drive o_busy = 1 in ISSUE and WAIT_DONE, and 0 in IDLE.
REQ-025 SHALL need at least 3 cycles from IDLE request to o_cmd_valid handshake completion: arbitrate (1) + ISSUE (≥1) + grant (1).

Reset
REQ-026 SHALL, while i_rstn = 0 (asynchronous), force:
- state IDLE; refresh counter REFRESH_CYCLES-1; refresh_pending 0
- all outputs 0, including o_cmd_type 00, o_cmd_addr 0, both sticky flags and round-robin pointer (read favoured)
- watchdog 0.
REQ-027 SHALL, on reset asserted mid-burst, drop the command immediately with no done pulse and restart from IDLE after i_rstn rises.

Verification
REQ-028 SHALL cover: i_wr_req=1 with addr 23'h000200, i_cmd_ready=1 -> o_cmd_valid, type 01, addr 23'h000200; o_wr_grant one cycle later; i_cmd_done -> o_wr_done next cycle.
REQ-029 SHALL cover: i_rd_req and i_wr_req held continuously with prompt done -> grants alternate R, W, R, W.
REQ-030 SHALL cover: both requests, i_rd_urgent=1, last grant = read -> read wins again.
REQ-031 SHALL cover: REFRESH_CYCLES=16, write burst lasting 40 cycles -> o_refresh_overrun=1; refresh (type 10, addr 0) issued before any pending read or write.
REQ-032 SHALL cover: TIMEOUT_CYCLES=8, no i_cmd_done -> o_timeout_err=1 after 8 WAIT_DONE cycles, FSM IDLE, no done pulse.
REQ-033 SHALL cover: i_rstn pulsed low during WAIT_DONE -> outputs 0 asynchronously; next request served normally after release.
